sr_latch_write_encoder: RTL and testbench
=========================================

// Module: sr_latch_write_encoder
// PURPOSE
//   Write-side driver for our gated set/reset storage cell. The cell decodes
//   (D,S) while its enable is high: D&~S -> 0, S&~D -> 1, ~D&~S -> hold, D&S -> illegal.
//   This block queues single-bit write requests and encodes each one into a
//   safe D/S/En pulse sequence: setup, enable pulse, hold. D and S are never high together.
//   It also keeps a model of the cell contents for checking.
// PARAMETERS
//   FIFO_DEPTH  4  request queue entries (power of 2, >=2)
//   SETUP_CYC   1  cycles D/S are stable before En rises (>=1)
//   PULSE_CYC   2  cycles En is high (>=1)
//   HOLD_CYC    1  cycles D/S stay stable after En falls (>=1)
// PORTS
//   Clock      in   1               single clock; all logic on posedge
//   Reset      in   1               synchronous, active-high
//   req_valid  in   1               write request present
//   req_bit    in   1               value to store in the cell
//   req_ready  out  1               queue can accept; push = req_valid & req_ready
//   D          out  1               reset-drive to cell (stores 0)
//   S          out  1               set-drive to cell (stores 1)
//   En         out  1               cell enable (gate)
//   busy       out  1               state != IDLE
//   done       out  1               1-cycle pulse when a write completes
//   q_model    out  1               last completed written value
//   level      out  $clog2(FIFO_DEPTH)+1  queued entries
// BEHAVIOUR
//   - All outputs are registered. "Cycle k" is the interval after posedge k.
//   - Reset has priority over every other event and is sampled at the posedge.
//     It forces state=IDLE, D=S=En=0, done=0, q_model=0, level=0, FIFO flushed.
//     It has the same effect mid-operation; the in-flight write and queued writes are dropped.
//   - FIFO: req_ready = (level < FIFO_DEPTH), so it is 1 when empty. Order is preserved.
//     Push and pop on the same edge leave level unchanged. There is no bypass.
//     A request always enters the FIFO first.
//   - FSM states: IDLE, SETUP, PULSE, HOLD. A down-counter times each phase.
//   - IDLE: D=S=En=0. If level>0 at the edge: pop, latch the bit, go to SETUP.
//   - SETUP (SETUP_CYC cycles): bit=0 -> D=1,S=0; bit=1 -> S=1,D=0. En=0.
//   - PULSE (PULSE_CYC cycles): D/S unchanged, En=1.
//   - HOLD (HOLD_CYC cycles): D/S unchanged, En=0. The edge leaving HOLD does three things:
//     go to IDLE, set D=S=0, and in that same cycle assert done=1 and q_model=bit.
//   - Every write therefore contains at least 1 IDLE cycle with D=S=En=0, so D/S
//     never switch directly between 1 values.
//   - Latency: a push at edge t gives D/S active in cycles t+1..t+SETUP+PULSE+HOLD.
//     En is high in cycles t+1+SETUP .. t+SETUP+PULSE. done is high in cycle t+1+SETUP+PULSE+HOLD.
//   - Throughput: 1 write per (1+SETUP_CYC+PULSE_CYC+HOLD_CYC) cycles, i.e. 5 at defaults.
//   - Invariant: D&S == 0 in every cycle. En=1 only in PULSE, and D^S==1 whenever En=1.
//   - A write of the same value as q_model is still performed; there is no suppression.
// TESTING
//   1 Reset 2 cycles with req_valid=1 -> D=S=En=done=0, level=0, req_ready=1, q_model=0.
//   2 Defaults; push bit=1 at edge 0 -> S=1 in cycles 1-4, En=1 in cycles 2-3, D=0 throughout,
//     done=1 in cycle 5 only, q_model=1 from cycle 5.
//   3 Push 0,1,0 at edges 0,1,2 -> done in cycles 5,10,15. q_model goes 0,1,0.
//     D=S=0 in cycles 5 and 10. D&S never 1.
//   4 Hold req_valid=1 for 12 cycles with incrementing bit pattern -> req_ready falls at level=4.
//     Accepted requests complete in order, none lost or duplicated.
//   5 Push bit=1, assert Reset in cycle 2 (PULSE) -> En=S=0 from cycle 3, done never pulses.
//     q_model=0, level=0.
//   6 SETUP_CYC=2, PULSE_CYC=3, HOLD_CYC=2, push bit=0 at edge 0 -> D=1 in cycles 1-7,
//     En=1 in cycles 3-5, done=1 in cycle 8.

Source files
------------

// File: rtl/sr_latch_write_encoder.sv
// Write-side driver for a gated set/reset storage cell: queues single-bit writes
// and turns each into a setup / enable-pulse / hold sequence on D, S and En.
module sr_latch_write_encoder #(
    parameter int FIFO_DEPTH = 4,
    parameter int SETUP_CYC  = 1,
    parameter int PULSE_CYC  = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic                          i_clk,
    input  logic                          i_srst,
    input  logic                          i_req_valid,
    input  logic                          i_req_bit,
    output logic                          o_req_ready,
    output logic                          o_d,
    output logic                          o_s,
    output logic                          o_en,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_q_model,
    output logic [$clog2(FIFO_DEPTH):0]   o_level
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int MAX_A   = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int CNT_MAX = (MAX_A > HOLD_CYC) ? MAX_A : HOLD_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PULSE = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------
    logic                  r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [LVL_W-1:0]      r_level;
    logic [LVL_W-1:0]      w_level_next;
    logic                  r_ready;
    logic                  w_push;
    logic                  w_pop;
    logic [FIFO_DEPTH-1:0] w_wr_sel;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_bit;
    logic                  r_d;
    logic                  r_s;
    logic                  r_en;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_q_model;

    assign w_push = i_req_valid && r_ready;
    // The FSM only dequeues from IDLE, and only entries already stored before this edge.
    assign w_pop  = (r_state == ST_IDLE) && (r_level != '0);

    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_wr_sel
            assign w_wr_sel[gi] = w_push && (r_wr_ptr == PTR_W'(gi));
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (w_wr_sel[i]) begin
                r_mem[i] <= i_req_bit;
            end
        end
    end

    always_comb begin
        w_level_next = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_next = r_level + 1'b1;
            2'b01:   w_level_next = r_level - 1'b1;
            default: w_level_next = r_level;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ready  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_level <= w_level_next;
            r_ready <= (w_level_next < LVL_W'(FIFO_DEPTH));
        end
    end

    // ------------------------------------------------------------------
    // Pulse sequencer: each phase is timed by a down-counter loaded with N-1
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bit     <= 1'b0;
            r_d       <= 1'b0;
            r_s       <= 1'b0;
            r_en      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_q_model <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_bit   <= r_mem[r_rd_ptr];
                        r_d     <= ~r_mem[r_rd_ptr];
                        r_s     <= r_mem[r_rd_ptr];
                        r_en    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_cnt   <= CNT_W'(SETUP_CYC - 1);
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (r_cnt == '0) begin
                        r_en    <= 1'b1;
                        r_cnt   <= CNT_W'(PULSE_CYC - 1);
                        r_state <= ST_PULSE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (r_cnt == '0) begin
                        r_en    <= 1'b0;
                        r_cnt   <= CNT_W'(HOLD_CYC - 1);
                        r_state <= ST_HOLD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (r_cnt == '0) begin
                        // Release both drives while reporting completion, forcing an all-low cycle.
                        r_d       <= 1'b0;
                        r_s       <= 1'b0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_q_model <= r_bit;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_d     <= 1'b0;
                    r_s     <= 1'b0;
                    r_en    <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_req_ready = r_ready;
    assign o_d         = r_d;
    assign o_s         = r_s;
    assign o_en        = r_en;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_q_model   = r_q_model;
    assign o_level     = r_level;

endmodule

// File: tb/tb_sr_latch_write_encoder.sv
// Randomised bench for sr_latch_write_encoder against a write-schedule model:
// each accepted request is given a start cycle and all outputs follow from it.
module tb_sr_latch_write_encoder;

    logic       clk = 1'b0;
    logic       i_srst = 1'b1;
    logic       i_req_valid = 1'b0;
    logic       i_req_bit = 1'b0;

    logic       a_ready, a_d, a_s, a_en, a_busy, a_done, a_q;
    logic [2:0] a_level;
    logic       b_ready, b_d, b_s, b_en, b_busy, b_done, b_q;
    logic [2:0] b_level;

    always #5 clk = ~clk;

    sr_latch_write_encoder #(.FIFO_DEPTH(4), .SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1)) u_dut_a (
        .i_clk(clk), .i_srst(i_srst), .i_req_valid(i_req_valid), .i_req_bit(i_req_bit),
        .o_req_ready(a_ready), .o_d(a_d), .o_s(a_s), .o_en(a_en), .o_busy(a_busy),
        .o_done(a_done), .o_q_model(a_q), .o_level(a_level)
    );

    sr_latch_write_encoder #(.FIFO_DEPTH(4), .SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(2)) u_dut_b (
        .i_clk(clk), .i_srst(i_srst), .i_req_valid(i_req_valid), .i_req_bit(i_req_bit),
        .o_req_ready(b_ready), .o_d(b_d), .o_s(b_s), .o_en(b_en), .o_busy(b_busy),
        .o_done(b_done), .o_q_model(b_q), .o_level(b_level)
    );

    typedef struct {
        int start;
        bit b;
    } wr_t;

    wr_t q_wr[$];
    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    int  last_done = -100;
    bit  q_cur = 0;
    bit  model_ready = 0;
    bit  phase = 0;
    int  m_s = 1, m_p = 2, m_h = 1;
    int  done_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d phase=%0d got=%0h expected=%0h", tag, cyc, phase, obs, exp);
        end
    endtask

    task automatic check_cycle();
        int  t;
        int  lvl;
        bit  e_d, e_s, e_en, e_busy, e_done;
        logic o_rdy, o_d, o_s, o_en, o_busy, o_done, o_q;
        logic [2:0] o_lvl;
        t = m_s + m_p + m_h;
        e_done = 0;
        while (q_wr.size() > 0 && q_wr[0].start + t <= cyc) begin
            if (q_wr[0].start + t == cyc) e_done = 1;
            q_cur = q_wr[0].b;
            void'(q_wr.pop_front());
        end
        lvl = 0;
        foreach (q_wr[k]) if (q_wr[k].start > cyc) lvl++;
        e_d = 0; e_s = 0; e_en = 0; e_busy = 0;
        if (q_wr.size() > 0 && q_wr[0].start <= cyc) begin
            e_busy = 1;
            e_d    = !q_wr[0].b;
            e_s    = q_wr[0].b;
            e_en   = (cyc >= q_wr[0].start + m_s) && (cyc < q_wr[0].start + m_s + m_p);
        end
        model_ready = (lvl < 4);
        if (phase) begin
            o_rdy = b_ready; o_d = b_d; o_s = b_s; o_en = b_en;
            o_busy = b_busy; o_done = b_done; o_q = b_q; o_lvl = b_level;
        end else begin
            o_rdy = a_ready; o_d = a_d; o_s = a_s; o_en = a_en;
            o_busy = a_busy; o_done = a_done; o_q = a_q; o_lvl = a_level;
        end
        if (o_done === 1'b1) done_seen++;
        chk("ready", {31'd0, o_rdy}, {31'd0, model_ready});
        chk("level", {29'd0, o_lvl}, lvl);
        chk("D", {31'd0, o_d}, {31'd0, e_d});
        chk("S", {31'd0, o_s}, {31'd0, e_s});
        chk("En", {31'd0, o_en}, {31'd0, e_en});
        chk("busy", {31'd0, o_busy}, {31'd0, e_busy});
        chk("done", {31'd0, o_done}, {31'd0, e_done});
        chk("q_model", {31'd0, o_q}, {31'd0, q_cur});
        chk("ds_excl", {31'd0, o_d & o_s}, 32'd0);
        chk("en_onehot", {31'd0, (o_en ? (o_d ^ o_s) : 1'b1)}, 32'd1);
    endtask

    task automatic run_cycle(input bit v, input bit b, input bit r);
        bit push;
        i_req_valid = v;
        i_req_bit   = b;
        i_srst      = r;
        push = v && !r && model_ready;
        @(posedge clk);
        cyc++;
        if (r) begin
            q_wr.delete();
            q_cur = 0;
            last_done = -100;
        end else if (push) begin
            wr_t w;
            w.start = (cyc + 1 > last_done + 1) ? cyc + 1 : last_done + 1;
            w.b = b;
            last_done = w.start + m_s + m_p + m_h;
            q_wr.push_back(w);
        end
        #1;
        check_cycle();
        $display("cyc=%0d phase=%0d v=%0b bit=%0b rst=%0b push=%0b queued=%0d", cyc, phase, v, b, r, push, q_wr.size());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle(0, 0, 0);
    endtask

    initial begin
        int d0;
        // Reset with a request pending
        run_cycle(1, 1, 1);
        run_cycle(1, 1, 1);
        // Single write of 1
        run_cycle(1, 1, 0);
        idle(8);
        // Back-to-back writes 0,1,0
        d0 = done_seen;
        run_cycle(1, 0, 0);
        run_cycle(1, 1, 0);
        run_cycle(1, 0, 0);
        idle(16);
        chk("three_dones", done_seen - d0, 3);
        // Sustained valid fills the queue
        for (int i = 0; i < 12; i++) run_cycle(1, i[0], 0);
        idle(30);
        // Reset during the enable pulse
        run_cycle(1, 1, 0);
        run_cycle(0, 0, 0);
        run_cycle(0, 0, 0);
        d0 = done_seen;
        run_cycle(0, 0, 1);
        idle(8);
        chk("no_done_after_rst", done_seen - d0, 0);
        // Same-value rewrite still executes
        run_cycle(1, 0, 0);
        idle(6);
        d0 = done_seen;
        run_cycle(1, 0, 0);
        idle(6);
        chk("rewrite_done", done_seen - d0, 1);
        // Random traffic with rare resets
        for (int i = 0; i < 400; i++)
            run_cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 99) == 0);

        // Longer phase timing on the second instance
        phase = 1;
        m_s = 2; m_p = 3; m_h = 2;
        run_cycle(0, 0, 1);
        run_cycle(0, 0, 1);
        run_cycle(1, 0, 0);
        idle(12);
        for (int i = 0; i < 12; i++) run_cycle(1, i[1], 0);
        idle(40);
        for (int i = 0; i < 300; i++)
            run_cycle($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 99) == 0);
        idle(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
